// File: rtl/xor_serial_ctrl.sv
// Bit-serial W-bit XOR sequencer. One 1-bit xor_gate is reused for every bit
// position; operands enter on a valid/ready port and the result leaves on another.

module xor_gate (
   input  logic a,
   input  logic b,
   output logic out
);
   assign out = a ^ b;
endmodule

// state | meaning
// IDLE  | ready for operands, in_ready=1
// RUN   | one bit per cycle through the gate, LSB first
// DONE  | result presented, waiting on out_ready
module xor_serial_ctrl #(
   parameter int W  = 8,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_a,
   input  logic [W-1:0]  in_b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic          busy,
   output logic [CW-1:0] op_count
);

   // Counter kept at least 1 bit wide so W=1 still has a compare against 0.
   localparam int CNTW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CNTW-1:0] LAST = CNTW'(W - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic [W-1:0]    a_sh, b_sh, res;
   logic [CNTW-1:0] bit_cnt;
   logic            gate_out;
   logic            accept;
   logic            deliver;

   xor_gate u_xor (
      .a   (a_sh[0]),
      .b   (b_sh[0]),
      .out (gate_out)
   );

   assign accept  = in_valid  && (state == IDLE);
   assign deliver = out_ready && (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)          state_nxt = RUN;
         RUN:     if (bit_cnt == LAST)   state_nxt = DONE;
         DONE:    if (out_ready)         state_nxt = IDLE;
         default:                        state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   // Gate output enters at the MSB; after W shifts bit 0 lands in res[0].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         res     <= '0;
         bit_cnt <= '0;
      end else if (accept) begin
         a_sh    <= in_a;
         b_sh    <= in_b;
         res     <= '0;
         bit_cnt <= '0;
      end else if (state == RUN) begin
         a_sh    <= a_sh >> 1;
         b_sh    <= b_sh >> 1;
         res     <= (res >> 1) | (W'(gate_out) << (W - 1));
         bit_cnt <= bit_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       op_count <= '0;
      else if (deliver) op_count <= op_count + 1'b1;
   end

   assign out_data = res;

endmodule

// File: tb/tb_xor_serial_ctrl.sv
// Self-checking bench for xor_serial_ctrl: W=8 main instance, plus CW=2 and
// W=1 instances for counter wrap and single-bit width.

module tb_xor_serial_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // main instance, W=8 CW=16
   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
   logic [7:0]  in_a = '0, in_b = '0, out_data;
   logic [15:0] op_count;

   xor_serial_ctrl #(.W(8), .CW(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .busy(busy), .op_count(op_count));

   // wrap instance, W=8 CW=2
   logic       c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0, c_busy;
   logic [7:0] c_in_a = '0, c_in_b = '0, c_out_data;
   logic [1:0] c_op_count;

   xor_serial_ctrl #(.W(8), .CW(2)) dut_cw2 (
      .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_a(c_in_a), .in_b(c_in_b), .out_valid(c_out_valid), .out_ready(c_out_ready),
      .out_data(c_out_data), .busy(c_busy), .op_count(c_op_count));

   // single-bit instance, W=1 CW=4
   logic       w_in_valid = 1'b0, w_in_ready, w_out_valid, w_out_ready = 1'b0, w_busy;
   logic [0:0] w_in_a = '0, w_in_b = '0, w_out_data;
   logic [3:0] w_op_count;

   xor_serial_ctrl #(.W(1), .CW(4)) dut_w1 (
      .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
      .in_a(w_in_a), .in_b(w_in_b), .out_valid(w_out_valid), .out_ready(w_out_ready),
      .out_data(w_out_data), .busy(w_busy), .op_count(w_op_count));

   logic [7:0] sb[$];
   logic [7:0] csb[$];
   logic [0:0] wsb[$];
   int exp_cnt = 0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic accept_op(input logic [7:0] a, input logic [7:0] b, output int t0);
      int n = 0;
      while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
      end
      in_valid = 1'b1; in_a = a; in_b = b;
      @(posedge clk); #1;
      t0 = cyc;
      sb.push_back(a ^ b);
      in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
   endtask

   task automatic wait_out(input int t0, input int lat);
      int n = 0;
      logic [7:0] exp;
      while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
      end
      checks++;
      if (cyc - t0 != lat) begin
         errors++; $display("FAIL latency: got %0d cycles required %0d", cyc - t0, lat);
      end
      checks++;
      if (sb.size() == 0) begin
         errors++; $display("FAIL scoreboard_empty: out_data=%h required no output", out_data);
      end else begin
         exp = sb.pop_front();
         if (out_data !== exp) begin
            errors++; $display("FAIL out_data: got %h required %h", out_data, exp);
         end
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      exp_cnt++;
      checks++;
      if (op_count !== 16'(exp_cnt)) begin
         errors++; $display("FAIL op_count: got %0d required %0d", op_count, exp_cnt);
      end
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL back_to_idle: in_ready=%b out_valid=%b busy=%b required 1 0 0",
                  in_ready, out_valid, busy);
      end
   endtask

   task automatic check_reset_values(input string tag);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
          op_count !== 16'd0 || out_data !== 8'd0) begin
         errors++;
         $display("FAIL %s: in_ready=%b out_valid=%b busy=%b op_count=%0d out_data=%h required 1 0 0 0 00",
                  tag, in_ready, out_valid, busy, op_count, out_data);
      end
      checks++;
      if (c_op_count !== 2'd0 || w_op_count !== 4'd0 || c_in_ready !== 1'b1 || w_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_aux: c_op_count=%0d w_op_count=%0d c_in_ready=%b w_in_ready=%b required 0 0 1 1",
                  tag, c_op_count, w_op_count, c_in_ready, w_in_ready);
      end
   endtask

   task automatic test_reset();
      #3 rst_n = 1'b0;
      #1 check_reset_values("reset");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int t0;
      accept_op(8'hA5, 8'h3C, t0);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL run_flags: busy=%b in_ready=%b required 1 0", busy, in_ready);
      end
      wait_out(t0, 8);
      handshake();
   endtask

   task automatic test_back_to_back();
      logic [7:0] ta[4], tb[4];
      logic [7:0] exp;
      int i = 0, got = 0, last = -1;
      logic acc;
      ta = '{8'h00, 8'h00, 8'hFF, 8'hFF};
      tb = '{8'h00, 8'hFF, 8'h00, 8'hFF};
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = ta[0]; in_b = tb[0];
      for (int n = 0; n < 100 && got < 4; n++) begin
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) begin
            sb.push_back(in_a ^ in_b);
            if (last >= 0) begin
               checks++;
               if (cyc - last != 10) begin
                  errors++; $display("FAIL accept_spacing: got %0d required 10", cyc - last);
               end
            end
            last = cyc;
            i++;
            if (i < 4) begin in_a = ta[i]; in_b = tb[i]; end
            else in_valid = 1'b0;
         end
         if (out_valid === 1'b1) begin
            got++;
            exp_cnt++;
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL truth_empty: out_data=%h required no output", out_data);
            end else begin
               exp = sb.pop_front();
               if (out_data !== exp) begin
                  errors++; $display("FAIL truth_data: got %h required %h", out_data, exp);
               end
            end
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (got != 4) begin
         errors++; $display("FAIL truth_count: got %0d results required 4", got);
      end
      checks++;
      if (op_count !== 16'(exp_cnt)) begin
         errors++; $display("FAIL truth_op_count: got %0d required %0d", op_count, exp_cnt);
      end
   endtask

   task automatic test_backpressure();
      int t0;
      logic [7:0] held;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 out_ready = 1'b0;
      checks++;
      if (op_count !== 16'(exp_cnt)) begin
         errors++; $display("FAIL idle_out_ready: op_count=%0d required %0d", op_count, exp_cnt);
      end
      accept_op(8'h6B, 8'h2D, t0);
      wait_out(t0, 8);
      held = out_data;
      for (int k = 0; k < 5; k++) begin
         in_valid = (k % 2 == 0); in_a = 8'hFF; in_b = 8'h11;
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'h46 || out_data !== held || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure: out_valid=%b out_data=%h in_ready=%b required 1 46 0",
                     out_valid, out_data, in_ready);
         end
      end
      in_valid = 1'b0;
      handshake();
   endtask

   task automatic test_reset_mid();
      int t0;
      accept_op(8'hF0, 8'h0F, t0);
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_run_valid: out_valid=%b required 0", out_valid);
         end
      end
      rst_n = 1'b0;
      #1 check_reset_values("reset_mid");
      sb.delete();
      exp_cnt = 0;
      @(negedge clk) rst_n = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: out_valid=%b busy=%b required 0 0", out_valid, busy);
         end
      end
      accept_op(8'h12, 8'h34, t0);
      wait_out(t0, 8);
      handshake();
   endtask

   task automatic test_wrap();
      logic [7:0] exp;
      int n;
      for (int k = 0; k < 4; k++) begin
         c_in_valid = 1'b1; c_in_a = 8'(k * 17); c_in_b = 8'h0F;
         csb.push_back(8'(k * 17) ^ 8'h0F);
         @(posedge clk); #1;
         c_in_valid = 1'b0;
         n = 0;
         while (c_out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
         exp = csb.pop_front();
         checks++;
         if (c_out_valid !== 1'b1 || c_out_data !== exp) begin
            errors++; $display("FAIL wrap_data: out_valid=%b out_data=%h required 1 %h",
                               c_out_valid, c_out_data, exp);
         end
         c_out_ready = 1'b1;
         @(posedge clk); #1;
         c_out_ready = 1'b0;
         checks++;
         if (c_op_count !== 2'((k + 1) % 4)) begin
            errors++; $display("FAIL wrap_count: got %0d required %0d", c_op_count, (k + 1) % 4);
         end
      end
   endtask

   task automatic test_w1();
      logic [1:0] ops[2];
      logic [0:0] exp;
      ops = '{2'b11, 2'b10};
      for (int k = 0; k < 2; k++) begin
         w_in_valid = 1'b1; w_in_a = ops[k][1]; w_in_b = ops[k][0];
         wsb.push_back(ops[k][1] ^ ops[k][0]);
         @(posedge clk); #1;
         w_in_valid = 1'b0;
         checks++;
         if (w_out_valid !== 1'b0 || w_busy !== 1'b1) begin
            errors++; $display("FAIL w1_run: out_valid=%b busy=%b required 0 1", w_out_valid, w_busy);
         end
         @(posedge clk); #1;
         exp = wsb.pop_front();
         checks++;
         if (w_out_valid !== 1'b1 || w_out_data !== exp) begin
            errors++; $display("FAIL w1_done: out_valid=%b out_data=%b required 1 %b",
                               w_out_valid, w_out_data, exp);
         end
         w_out_ready = 1'b1;
         @(posedge clk); #1;
         w_out_ready = 1'b0;
         checks++;
         if (w_op_count !== 4'(k + 1) || w_in_ready !== 1'b1) begin
            errors++; $display("FAIL w1_count: op_count=%0d in_ready=%b required %0d 1",
                               w_op_count, w_in_ready, k + 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_wrap();
      test_w1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/xor_serial_ctrl.md
Name: xor_serial_ctrl

Overview:
- Bit-serial sequencer that computes the W-bit XOR of two operands. It uses one instance of the team's existing 1-bit `xor_gate` (ports a, b, out), time-shared across all W bit positions.
- Operands are accepted on a valid/ready input port. The result is returned on a valid/ready output port.
- Used where area matters more than throughput. It also serves as the reference sequencer for the gate library's single-bit cells.

Parameters:
- W, 8, operand/result width in bits; legal range 1..32.
- CW, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_data  output  W  in_a XOR in_b of the accepted pair.
- busy  output  1  high in RUN or DONE.
- op_count  output  CW  number of completed output handshakes, wraps modulo 2^CW.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; shift registers, bit counter, out_data and op_count all 0.
  - in_ready=1, out_valid=0, busy=0.
- State machine, three states:
  - IDLE:
    - in_ready=1.
    - On in_valid&&in_ready (edge T0): load a_sh<=in_a, b_sh<=in_b, res<=0, bit counter<=0; go to RUN.
  - RUN:
    - in_ready=0.
    - xor_gate inputs are a_sh[0] and b_sh[0].
    - Each edge: res <= {gate_out, res[W-1:1]} (LSB first, entering at MSB); a_sh and b_sh shift right by 1; counter increments.
    - On the edge where counter==W-1, go to DONE. After W RUN edges, res holds the full result.
  - DONE:
    - out_valid=1; out_data=res, held stable while out_ready=0.
    - On out_ready: op_count+1 (wraps); go to IDLE.
- Latency:
  - Accept at edge T0; out_valid is first high after edge T0+W.
  - Minimum spacing between accepts is W+2 cycles.
- out_data is driven from a register (res) and is valid only while out_valid=1.
- in_valid during RUN or DONE is ignored: no accept and no operand corruption. The producer must hold its data until in_ready.
- out_ready while not in DONE has no effect.
- Inputs in_a/in_b are sampled only at the accept edge. Later changes do not affect the result.
- W=1: RUN lasts exactly one cycle; the counter comparison against W-1=0 must still work.
- Reset asserted mid-RUN or mid-DONE:
  - Immediate return to reset values.
  - The partial result is discarded; op_count clears.
  - No out_valid pulse.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
1. Reset:
   - Assert rst_n=0 mid-cycle.
   - Check immediately, without waiting for an edge: in_ready=1, out_valid=0, busy=0, op_count=0, out_data=0.
2. Basic op, W=8:
   - Drive in_a=8'hA5, in_b=8'h3C with in_valid for one cycle.
   - out_valid rises exactly 8 edges after accept with out_data=8'h99.
   - With out_ready=1: op_count=1, back to IDLE the next cycle.
3. Truth table per bit, mirroring the gate cases:
   - Operands 00/00, 00/FF, FF/00, FF/FF give 00, FF, FF, 00.
   - Run back-to-back; each accept occurs exactly 10 cycles after the previous one.
4. Backpressure and ignored input:
   - Hold out_ready=0 for 5 cycles in DONE: out_valid and out_data stay constant.
   - Meanwhile pulse in_valid with new operands: in_ready stays 0, and the result is unchanged.
5. Reset mid-operation:
   - Accept 8'hF0/8'h0F, then assert rst_n=0 after 3 RUN edges.
   - All outputs return to reset values; no out_valid is ever observed.
   - A following op 8'h12/8'h34 yields 8'h26.
6. Wrap and width boundaries:
   - CW=2: run 4 ops; op_count reads 1, 2, 3, 0.
   - W=1: 1^1 gives 0 with out_valid one edge after accept.
